// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle around the memory arbiter: both requester ports plus the shared memory port.
// The "master" view belongs to the arbiter, which owns the shared memory bus.
// The "slave" view belongs to the attached requesters and memory.
interface mem_bus_arbiter_if #(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
);
    // M0: instruction fetch
    logic            m0_req;
    logic            m0_we;
    logic [AW-1:0]   m0_addr;
    logic [DW-1:0]   m0_wdata;
    logic [DW/8-1:0] m0_wstrb;
    logic            m0_gnt;
    logic            m0_rvalid;
    logic [DW-1:0]   m0_rdata;
    logic            m0_err;
    // M1: load/store unit
    logic            m1_req;
    logic            m1_we;
    logic [AW-1:0]   m1_addr;
    logic [DW-1:0]   m1_wdata;
    logic [DW/8-1:0] m1_wstrb;
    logic            m1_gnt;
    logic            m1_rvalid;
    logic [DW-1:0]   m1_rdata;
    logic            m1_err;
    // Shared memory port
    logic            s_req;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_ack;
    logic [DW-1:0]   s_rdata;

    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output s_req, s_we, s_addr, s_wdata, s_wstrb,
        input  s_ack, s_rdata
    );

    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  s_req, s_we, s_addr, s_wdata, s_wstrb,
        output s_ack, s_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester single-port memory arbiter: M1 has fixed priority, a starvation counter
// forces M0 through after MAX_WAIT consecutive M1 wins, and a watchdog aborts unacked accesses.
module mem_bus_arbiter #(
    parameter int unsigned AW       = 64,
    parameter int unsigned DW       = 64,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.master bus
);
    localparam int unsigned SW         = DW / 8;
    localparam logic [3:0]  STARVE_MAX = 4'(MAX_WAIT);
    localparam bit          TMO_EN     = (TIMEOUT != 0);
    localparam logic [7:0]  TMO_LAST   = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic          owner_q;  // 0 = M0, 1 = M1
    logic [3:0]    starve_cnt_q;
    logic [7:0]    tmo_cnt_q;
    logic          err_q;
    logic          s_we_q;
    logic [AW-1:0] s_addr_q;
    logic [DW-1:0] s_wdata_q;
    logic [SW-1:0] s_wstrb_q;
    logic [DW-1:0] m0_rdata_q, m1_rdata_q;

    logic m0_gnt, m1_gnt, grant, done, abort, m0_win;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next state, grant decision and completion events
    always_comb begin
        state_d = state_q;
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        m0_win  = bus.m0_req && (!bus.m1_req || (starve_cnt_q == STARVE_MAX));
        unique case (state_q)
            StIdle: begin
                if (!rst && (bus.m0_req || bus.m1_req)) begin
                    m0_gnt  = m0_win;
                    m1_gnt  = !m0_win;
                    state_d = StWait;
                end
            end
            StWait: begin
                // An ack in the expiry cycle still completes normally.
                if (bus.s_ack) begin
                    done    = 1'b1;
                    state_d = StResp;
                end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
                    abort   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign grant = m0_gnt || m1_gnt;

    // Request capture, starvation/timeout counters and response data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            starve_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
            s_we_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_wstrb_q    <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            if (grant) begin
                owner_q   <= m1_gnt;
                tmo_cnt_q <= '0;
                s_we_q    <= m1_gnt ? bus.m1_we    : bus.m0_we;
                s_addr_q  <= m1_gnt ? bus.m1_addr  : bus.m0_addr;
                s_wdata_q <= m1_gnt ? bus.m1_wdata : bus.m0_wdata;
                s_wstrb_q <= m1_gnt ? bus.m1_wstrb : bus.m0_wstrb;
                if (m1_gnt && bus.m0_req) begin
                    if (starve_cnt_q != STARVE_MAX) starve_cnt_q <= starve_cnt_q + 4'd1;
                end else begin
                    starve_cnt_q <= '0;
                end
            end
            if ((state_q == StWait) && !bus.s_ack) tmo_cnt_q <= tmo_cnt_q + 8'd1;
            if (done || abort) begin
                err_q <= abort;
                if (owner_q) m1_rdata_q <= done ? bus.s_rdata : '0;
                else         m0_rdata_q <= done ? bus.s_rdata : '0;
            end
            if (state_q == StResp) err_q <= 1'b0;
        end
    end

    assign bus.m0_gnt    = m0_gnt;
    assign bus.m1_gnt    = m1_gnt;
    assign bus.m0_rvalid = (state_q == StResp) && !owner_q;
    assign bus.m1_rvalid = (state_q == StResp) && owner_q;
    assign bus.m0_err    = (state_q == StResp) && !owner_q && err_q;
    assign bus.m1_err    = (state_q == StResp) && owner_q && err_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.s_req     = (state_q == StWait);
    assign bus.s_we      = s_we_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wdata   = s_wdata_q;
    assign bus.s_wstrb   = s_wstrb_q;

    // Requesters must hold req until granted; no recovery exists for a dropped request.
    m0_req_held: assert property (@(posedge clk) disable iff (rst)
        bus.m0_req && !bus.m0_gnt |=> bus.m0_req);
    m1_req_held: assert property (@(posedge clk) disable iff (rst)
        bus.m1_req && !bus.m1_gnt |=> bus.m1_req);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: two request agents, a random-latency memory,
// and a transaction-level scoreboard built from the arbitration and timeout rules.
module tb_mem_bus_arbiter;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned TIMEOUT  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   g0_seen = 0;
    int   g1_seen = 0;

    mem_bus_arbiter_if #(.AW(64), .DW(64)) bus ();

    mem_bus_arbiter #(
        .AW       (64),
        .DW       (64),
        .MAX_WAIT (MAX_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester M0: holds req until its grant has been observed, then maybe issues another.
    initial begin : m0_agent
        int seen;
        seen = 0;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m0_wstrb = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.m0_req = 1'b0;
                seen = g0_seen;
            end else if (!bus.m0_req || (seen != g0_seen)) begin
                seen         = g0_seen;
                bus.m0_req   = run_en && ($urandom_range(0, 3) != 0);
                bus.m0_we    = 1'($urandom_range(0, 1));
                bus.m0_addr  = {$urandom, $urandom};
                bus.m0_wdata = {$urandom, $urandom};
                bus.m0_wstrb = 8'($urandom);
            end
        end
    end

    // Requester M1
    initial begin : m1_agent
        int seen;
        seen = 0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.m1_wstrb = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.m1_req = 1'b0;
                seen = g1_seen;
            end else if (!bus.m1_req || (seen != g1_seen)) begin
                seen         = g1_seen;
                bus.m1_req   = run_en && ($urandom_range(0, 3) != 0);
                bus.m1_we    = 1'($urandom_range(0, 1));
                bus.m1_addr  = {$urandom, $urandom};
                bus.m1_wdata = {$urandom, $urandom};
                bus.m1_wstrb = 8'($urandom);
            end
        end
    end

    // Memory: acks on the k-th s_req cycle (k > TIMEOUT never acks in time); also throws
    // stray acks while idle and a late ack after any abandoned or aborted access.
    initial begin : mem_agent
        int cnt, k;
        bit acked;
        cnt = 0; k = 1; acked = 1'b0;
        bus.s_ack = 1'b0; bus.s_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.s_rdata = {$urandom, $urandom};
            if (bus.s_req) begin
                cnt++;
                bus.s_ack = (cnt == k);
                if (cnt == k) acked = 1'b1;
            end else begin
                bus.s_ack = ((cnt > 0) && !acked) || ($urandom_range(0, 7) == 0);
                cnt   = 0;
                acked = 1'b0;
                k     = $urandom_range(1, 10);
            end
        end
    end

    // Scoreboard state: 0 = arbiter free, 1 = access at memory, 2 = completion cycle
    int           phase = 0;
    int           age = 0;
    int           starve = 0;
    bit           own = 1'b0;
    bit           exp_err = 1'b0;
    logic [63:0]  exp_data = '0;
    logic [63:0]  last_rd [2];
    bit           t_we;
    logic [63:0]  t_addr, t_wdata;
    logic [7:0]   t_wstrb;

    task automatic monitor_step();
        bit e0, e1;
        if (bus.m0_gnt) g0_seen++;
        if (bus.m1_gnt) g1_seen++;
        if (rst) begin
            check_eq("rst_gnt", {bus.m0_gnt, bus.m1_gnt}, 0);
            check_eq("rst_rvalid_err", {bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err}, 0);
            check_eq("rst_rdata0", bus.m0_rdata, 0);
            check_eq("rst_rdata1", bus.m1_rdata, 0);
            check_eq("rst_s_req_we", {bus.s_req, bus.s_we}, 0);
            check_eq("rst_s_addr", bus.s_addr, 0);
            check_eq("rst_s_wdata", bus.s_wdata, 0);
            check_eq("rst_s_wstrb", bus.s_wstrb, 0);
            phase = 0; starve = 0; last_rd[0] = '0; last_rd[1] = '0;
            return;
        end
        case (phase)
            0: begin
                e0 = bus.m0_req && (!bus.m1_req || (starve == MAX_WAIT));
                e1 = bus.m1_req && !e0;
                check_eq("idle_m0_gnt", bus.m0_gnt, e0);
                check_eq("idle_m1_gnt", bus.m1_gnt, e1);
                check_eq("idle_rvalid", {bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err}, 0);
                check_eq("idle_s_req", bus.s_req, 0);
                if (e0 || e1) begin
                    own     = e1;
                    t_we    = e1 ? bus.m1_we    : bus.m0_we;
                    t_addr  = e1 ? bus.m1_addr  : bus.m0_addr;
                    t_wdata = e1 ? bus.m1_wdata : bus.m0_wdata;
                    t_wstrb = e1 ? bus.m1_wstrb : bus.m0_wstrb;
                    if (e1 && bus.m0_req) starve = (starve + 1 > MAX_WAIT) ? MAX_WAIT : starve + 1;
                    else                  starve = 0;
                    phase = 1;
                    age   = 0;
                end
            end
            1: begin
                check_eq("wait_s_req", bus.s_req, 1);
                check_eq("wait_s_we", bus.s_we, t_we);
                check_eq("wait_s_addr", bus.s_addr, t_addr);
                check_eq("wait_s_wdata", bus.s_wdata, t_wdata);
                check_eq("wait_s_wstrb", bus.s_wstrb, t_wstrb);
                check_eq("wait_gnt_rvalid", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid}, 0);
                age++;
                if (bus.s_ack) begin
                    exp_err = 1'b0; exp_data = bus.s_rdata; phase = 2;
                end else if (age == TIMEOUT) begin
                    exp_err = 1'b1; exp_data = '0; phase = 2;
                end
            end
            default: begin
                check_eq("resp_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, own ? 2'b10 : 2'b01);
                check_eq("resp_err", {bus.m1_err, bus.m0_err},
                         own ? {exp_err, 1'b0} : {1'b0, exp_err});
                check_eq("resp_s_req_gnt", {bus.s_req, bus.m0_gnt, bus.m1_gnt}, 0);
                last_rd[own] = exp_data;
                phase = 0;
            end
        endcase
        check_eq("m0_rdata", bus.m0_rdata, last_rd[0]);
        check_eq("m1_rdata", bus.m1_rdata, last_rd[1]);
    endtask

    initial begin : main
        int rst_hold, wait_cyc;
        bit arm;
        last_rd[0] = '0; last_rd[1] = '0;
        #1 rst = 1'b1;
        rst_hold = 3; wait_cyc = 0; arm = 1'b0;
        run_en = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            monitor_step();
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst = 1'b0;
            end else if ((cyc % 900) == 899) begin
                arm = 1'b1;
                wait_cyc = 0;
            end
            // Reset landing while an access is outstanding at memory.
            if (arm && (rst_hold == 0) && !rst) begin
                if (bus.s_req) begin
                    rst = 1'b1; rst_hold = 2; arm = 1'b0;
                end else if (++wait_cyc > 200) begin
                    check_eq("reach_wait", bus.s_req, 1);
                    arm = 1'b0;
                end
            end
        end
        run_en = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            monitor_step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
